// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH = 8;

  // Occupancy needs to represent 0..DEPTH inclusive.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_pw(input int depth);
    return $clog2(depth);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  parameter int PW    = fifo_pw(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy, almost-full/empty and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read behaviour.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW       = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_ful,
  output logic             fifo_emp,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            PW       = fifo_pw(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_param_err
    $error("fifo_sync_param: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] rdata;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // A push into a full FIFO is still taken when a pop frees the slot on the same edge.
  assign push_ok = push & (~full_q | pop);
  assign pop_ok  = pop & ~empty_q;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    full_d   = (count_d == FULL_LVL);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_LVL);
    aempty_d = (count_d <= AE_LVL);
    ovf_d    = push & ~push_ok;
    unf_d    = pop & ~pop_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AF_THRESH == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is shown directly; zero while nothing is stored.
  assign data_out = empty_q ? '0 : rdata;
`else
  logic [WIDTH-1:0] dout_q;

  // On a full push+pop the write lands in the slot being read, so the old head is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (pop_ok) begin
      dout_q <= rdata;
    end
  end

  assign data_out = dout_q;
`endif

  assign count        = count_q;
  assign fifo_ful     = full_q;
  assign fifo_emp     = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (DEPTH=4, WIDTH=16) against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop;
  logic [W-1:0]  data_in, data_out;
  logic          fifo_ful, fifo_emp, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  bit           exp_ovf, exp_unf;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .fifo_ful     (fifo_ful),
    .fifo_emp     (fifo_emp),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    logic [W-1:0] dexp;
    n = model_q.size();
`ifdef FIFO_FWFT_EN
    dexp = (n > 0) ? model_q[0] : '0;
`else
    dexp = exp_dout;
`endif
    check({tag, ".count"},        32'(count),   32'(n));
    check({tag, ".fifo_ful"},     fifo_ful,     n == D);
    check({tag, ".fifo_emp"},     fifo_emp,     n == 0);
    check({tag, ".almost_full"},  almost_full,  n >= AF);
    check({tag, ".almost_empty"}, almost_empty, n <= AE);
    check({tag, ".overflow"},     overflow,     exp_ovf);
    check({tag, ".underflow"},    underflow,    exp_unf);
    check({tag, ".data_out"},     data_out,     dexp);
  endtask

  // One clock of stimulus; the model applies the acceptance rules to its own queue.
  task automatic cycle(input bit p, input bit po, input logic [W-1:0] d, input string tag);
    int n;
    bit pok, pook;
    logic [W-1:0] popped;
    @(negedge clk);
    push = p; pop = po; data_in = d;
    n    = model_q.size();
    pook = po && (n > 0);
    pok  = p && ((n < D) || po);
    @(posedge clk);
    #1;
    if (pook) begin
      popped = model_q.pop_front();
      exp_dout = popped;
    end
    if (pok) begin
      model_q.push_back(d);
      exp_q.push_back(d);
    end
    exp_ovf = p && !pok;
    exp_unf = po && !pook;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    check_outputs(tag);
    #1 rst = 1'b0;
  endtask

  // Monitor: whenever the DUT is about to accept a pop, the popped word must match the scoreboard head.
  initial begin
    logic [W-1:0] want;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && pop && !fifo_emp) begin
        if (exp_q.size() == 0) begin
          check("sb.unexpected_pop", 32'(exp_q.size()), 32'd1);
        end else begin
          want = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
          check("sb.head", data_out, want);
`else
          @(posedge clk);
          #2;
          if (!rst) check("sb.read", data_out, want);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fill [4];
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    #3;
    check_outputs("reset0");
    #1 rst = 1'b0;

    fill = '{16'h000A, 16'h000D, 16'h0005, 16'h0009};
    foreach (fill[i]) cycle(1'b1, 1'b0, fill[i], "fill");
    cycle(1'b1, 1'b0, 16'h0001, "overflow");
    cycle(1'b0, 1'b0, 16'h0000, "ovf_clear");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0000, "drain");
    cycle(1'b0, 1'b1, 16'h0000, "underflow");
    cycle(1'b0, 1'b0, 16'h0000, "unf_clear");

    cycle(1'b1, 1'b0, 16'h0020, "pre2");
    cycle(1'b1, 1'b0, 16'h0021, "pre2");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, W'(16'h0011 + i), "pushpop_wrap");
    cycle(1'b1, 1'b0, 16'h0030, "refill");
    cycle(1'b1, 1'b0, 16'h0031, "refill");
    cycle(1'b1, 1'b1, 16'h0032, "full_pushpop");
    cycle(1'b0, 1'b1, 16'h0000, "to3");

    do_reset("reset_mid");
    cycle(1'b1, 1'b1, 16'h00BB, "empty_pushpop");
    cycle(1'b0, 1'b1, 16'h0000, "pop_bb");
    cycle(1'b1, 1'b0, 16'h00AA, "push_aa");
    cycle(1'b0, 1'b1, 16'h0000, "pop_aa");
    cycle(1'b0, 1'b0, 16'h0000, "idle");

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
            W'($urandom_range(0, 65535)), "rand");
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0000, "final_drain");
    cycle(1'b0, 1'b0, 16'h0000, "final_idle");
    check("sb.drain", 32'(exp_q.size()), 32'(model_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_sync_param
